// File: rtl/decode_stage.sv
// Instruction decode stage for the five-stage RV64 subset pipeline.
// Holds the register file, decodes R-type/ld/sd/beq, detects load-use
// hazards and drives the ID/EX pipeline register and forwarding selects.
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [63:0] pc_in,
    input  logic        in_valid,
    input  logic        flush,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] write_data,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_rd,
    output logic [63:0] a,
    output logic [63:0] readdata1,
    output logic [63:0] readdata2,
    output logic [63:0] d,
    output logic        Alusrc,
    output logic [1:0]  aluop,
    output logic [3:0]  funct4_out,
    output logic [1:0]  forwardA,
    output logic [1:0]  forwardB,
    output logic        ex_valid,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_branch,
    output logic        ex_regwrite,
    output logic        ex_memtoreg,
    output logic [4:0]  ex_rd,
    output logic        stall
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_DOUBLE = 3'b011;
    localparam logic [2:0] F3_BEQ    = 3'b000;

    logic [63:0] regs [0:31];

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    // Source registers of the instruction now in ID/EX, used for forwarding
    logic [4:0] rs1_q;
    logic [4:0] rs2_q;

    logic        dec_valid;
    logic        dec_memread;
    logic        dec_memwrite;
    logic        dec_branch;
    logic        dec_regwrite;
    logic        dec_memtoreg;
    logic        dec_alusrc;
    logic [1:0]  dec_aluop;
    logic [63:0] dec_imm;
    logic        uses_rs2;
    logic [63:0] rdata1;
    logic [63:0] rdata2;
    logic        bubble;

    // Register file write port; x0 is never written so it always reads back 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 64'd0;
            end
        end else if (wb_regwrite && (wb_rd != 5'd0)) begin
            regs[wb_rd] <= write_data;
        end
    end

    // Read port 1 with same-cycle bypass of the writeback value
    always_comb begin
        rdata1 = regs[rs1];
        if (rs1 == 5'd0) begin
            rdata1 = 64'd0;
        end else if (wb_regwrite && (wb_rd == rs1)) begin
            rdata1 = write_data;
        end
    end

    // Read port 2 with same-cycle bypass of the writeback value
    always_comb begin
        rdata2 = regs[rs2];
        if (rs2 == 5'd0) begin
            rdata2 = 64'd0;
        end else if (wb_regwrite && (wb_rd == rs2)) begin
            rdata2 = write_data;
        end
    end

    // Main decoder: anything outside the supported set becomes a bubble
    always_comb begin
        dec_valid    = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_branch   = 1'b0;
        dec_regwrite = 1'b0;
        dec_memtoreg = 1'b0;
        dec_alusrc   = 1'b0;
        dec_aluop    = 2'b00;
        dec_imm      = 64'd0;
        if (in_valid) begin
            case (opcode)
                OP_RTYPE: begin
                    dec_valid    = 1'b1;
                    dec_regwrite = 1'b1;
                    dec_aluop    = 2'b10;
                end
                OP_LOAD: begin
                    if (funct3 == F3_DOUBLE) begin
                        dec_valid    = 1'b1;
                        dec_memread  = 1'b1;
                        dec_memtoreg = 1'b1;
                        dec_regwrite = 1'b1;
                        dec_alusrc   = 1'b1;
                        dec_imm      = {{52{instr[31]}}, instr[31:20]};
                    end
                end
                OP_STORE: begin
                    if (funct3 == F3_DOUBLE) begin
                        dec_valid    = 1'b1;
                        dec_memwrite = 1'b1;
                        dec_alusrc   = 1'b1;
                        dec_imm      = {{52{instr[31]}}, instr[31:25], instr[11:7]};
                    end
                end
                OP_BRANCH: begin
                    if (funct3 == F3_BEQ) begin
                        dec_valid  = 1'b1;
                        dec_branch = 1'b1;
                        dec_aluop  = 2'b01;
                        dec_imm    = {{52{instr[31]}}, instr[31], instr[7],
                                      instr[30:25], instr[11:8]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Only R-type, sd and beq actually read rs2, so only they can hazard on it
    always_comb begin
        uses_rs2 = 1'b0;
        if ((opcode == OP_RTYPE) ||
            ((opcode == OP_STORE) && (funct3 == F3_DOUBLE)) ||
            ((opcode == OP_BRANCH) && (funct3 == F3_BEQ))) begin
            uses_rs2 = 1'b1;
        end
    end

    // Load-use hazard: the load result is not available until after MEM
    always_comb begin
        stall = 1'b0;
        if (ex_memread && (ex_rd != 5'd0)) begin
            if ((ex_rd == rs1) || (uses_rs2 && (ex_rd == rs2))) begin
                stall = 1'b1;
            end
        end
    end

    assign bubble = flush || stall || !dec_valid;

    // ID/EX pipeline register; a bubble clears only the control bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a           <= 64'd0;
            readdata1   <= 64'd0;
            readdata2   <= 64'd0;
            d           <= 64'd0;
            Alusrc      <= 1'b0;
            aluop       <= 2'b00;
            funct4_out  <= 4'd0;
            ex_valid    <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_rd       <= 5'd0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
        end else begin
            a          <= pc_in;
            readdata1  <= rdata1;
            readdata2  <= rdata2;
            d          <= dec_imm;
            funct4_out <= {instr[30], funct3};
            ex_rd      <= rd;
            rs1_q      <= rs1;
            rs2_q      <= rs2;
            if (bubble) begin
                Alusrc      <= 1'b0;
                aluop       <= 2'b00;
                ex_valid    <= 1'b0;
                ex_memread  <= 1'b0;
                ex_memwrite <= 1'b0;
                ex_branch   <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memtoreg <= 1'b0;
            end else begin
                Alusrc      <= dec_alusrc;
                aluop       <= dec_aluop;
                ex_valid    <= 1'b1;
                ex_memread  <= dec_memread;
                ex_memwrite <= dec_memwrite;
                ex_branch   <= dec_branch;
                ex_regwrite <= dec_regwrite;
                ex_memtoreg <= dec_memtoreg;
            end
        end
    end

    // Forwarding selects; the younger EX/MEM result wins over MEM/WB
    always_comb begin
        forwardA = 2'b00;
        forwardB = 2'b00;
        if (ex_valid) begin
            if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs1_q)) begin
                forwardA = 2'b10;
            end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs1_q)) begin
                forwardA = 2'b01;
            end
            if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs2_q)) begin
                forwardB = 2'b10;
            end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs2_q)) begin
                forwardB = 2'b01;
            end
        end
    end

endmodule
